// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Accumulate stage of the MAC unit. Takes registered signed operand pairs
//   (a, b), sums N_TERMS full-width products into a signed accumulator, and
//   hands the finished dot product to the consumer over valid/ready.
//
//   Ports
//     clk        rising-edge clock
//     reset      synchronous, active-low reset
//     start      begin a new result (accepted in IDLE, or in DONE with out_ready)
//     a, b       signed operands, WIDTH bits each
//     in_valid   a/b hold a valid pair
//     in_ready   stage accepts a pair this cycle (high in ACC)
//     acc_out    accumulator register, always visible
//     out_valid  acc_out holds a completed result (high in DONE)
//     out_ready  consumer takes the result
//     busy       high in ACC
//     overflow   sticky signed-overflow flag for the current result
//
//   Build option
//     MAC_SATURATE_EN  when defined, an overflowing addition clamps acc_out to
//                      the signed max/min matching the true sum's sign; when
//                      undefined the accumulator wraps modulo 2**ACC_WIDTH.
//                      overflow is flagged the same way in both builds.
//
//   ACC_WIDTH must be >= 2*WIDTH; N_TERMS must be in 1..2**CNT_WIDTH.

module mac_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20,
    parameter int N_TERMS   = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(N_TERMS - 1);

    state_t                 state;
    logic [CNT_WIDTH-1:0]   count;

    // Full-precision signed product: operands sign-extended to 2*WIDTH first
    // so the low 2*WIDTH bits of the multiply are the exact product.
    logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;
    // One guard bit above the accumulator so the true sum is always exact;
    // overflow is the guard bit disagreeing with the result's sign bit.
    logic signed [ACC_WIDTH:0] sum_ext;
    logic                      sum_ovf;
    logic [ACC_WIDTH-1:0]      acc_next;
    logic                      beat;

    assign a_ext   = (2*WIDTH)'(signed'(a));
    assign b_ext   = (2*WIDTH)'(signed'(b));
    assign prod    = a_ext * b_ext;
    assign sum_ext = (ACC_WIDTH+1)'(signed'(acc_out)) + (ACC_WIDTH+1)'(prod);
    assign sum_ovf = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
    assign beat    = in_valid && in_ready;

`ifdef MAC_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // The guard bit carries the sign of the true (unclamped) sum.
    always_comb begin
        acc_next = sum_ext[ACC_WIDTH-1:0];
        if (sum_ovf)
            acc_next = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
`else
    always_comb begin
        acc_next = sum_ext[ACC_WIDTH-1:0];
    end
`endif

    // Status outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            acc_out   <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACC;
                        acc_out  <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                ACC: begin
                    if (beat) begin
                        acc_out <= acc_next;
                        count   <= count + CNT_WIDTH'(1);
                        if (sum_ovf)
                            overflow <= 1'b1;
                        if (count == LAST_BEAT) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // Result holds until the consumer takes it; start alone is ignored.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            state    <= ACC;
                            acc_out  <= '0;
                            count    <= '0;
                            overflow <= 1'b0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a default-width instance for the main
// sequence, plus a 16-bit accumulator instance (overflow) and an N_TERMS=1
// instance sharing a secondary stimulus set.

module tb_mac_accumulator;

    logic clk = 1'b0;
    logic reset;

    // main instance
    logic        start, in_valid, out_ready;
    logic [7:0]  a, b;
    logic        in_ready, out_valid, busy, overflow;
    logic [19:0] acc_out;

    // secondary stimulus shared by the 16-bit and single-term instances
    logic        s_start, s_valid, s_ready;
    logic [7:0]  s_a, s_b;
    logic        w_in_ready, w_out_valid, w_busy, w_overflow;
    logic [15:0] w_acc;
    logic        o_in_ready, o_out_valid, o_busy, o_overflow;
    logic [19:0] o_acc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mac_accumulator dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .overflow(overflow)
    );

    mac_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .N_TERMS(4), .CNT_WIDTH(3)) dut16 (
        .clk(clk), .reset(reset), .start(s_start), .a(s_a), .b(s_b),
        .in_valid(s_valid), .in_ready(w_in_ready), .acc_out(w_acc),
        .out_valid(w_out_valid), .out_ready(s_ready), .busy(w_busy),
        .overflow(w_overflow)
    );

    mac_accumulator #(.WIDTH(8), .ACC_WIDTH(20), .N_TERMS(1), .CNT_WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(s_start), .a(s_a), .b(s_b),
        .in_valid(s_valid), .in_ready(o_in_ready), .acc_out(o_acc),
        .out_valid(o_out_valid), .out_ready(s_ready), .busy(o_busy),
        .overflow(o_overflow)
    );

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input int x, input int y);
        a = 8'(x); b = 8'(y); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 8'hxx; b = 8'hxx;
    endtask

    task automatic s_beat(input int x, input int y);
        s_a = 8'(x); s_b = 8'(y); s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0;
        s_start = 1'b0; s_valid = 1'b0; s_ready = 1'b0; s_a = '0; s_b = '0;

        // 1. reset
        step(); step();
        check("rst_acc",       $signed(acc_out), 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_busy",      busy,      0);
        check("rst_overflow",  overflow,  0);
        reset = 1'b1;
        step();

        // 2. basic dot product: 12 - 10 + 49 - 1 = 50
        do_start();
        check("t2_busy",     busy,     1);
        check("t2_in_ready", in_ready, 1);
        check("t2_acc0",     $signed(acc_out), 0);
        beat(3, 4);   check("t2_acc1", $signed(acc_out), 12);
        beat(-2, 5);  check("t2_acc2", $signed(acc_out), 2);
        beat(7, 7);   check("t2_acc3", $signed(acc_out), 51);
        check("t2_no_valid_early", out_valid, 0);
        beat(1, -1);
        check("t2_acc4",      $signed(acc_out), 50);
        check("t2_out_valid", out_valid, 1);
        check("t2_busy_done", busy, 0);
        // start and stray pairs without out_ready must not disturb the result
        start = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd5;
        for (int i = 0; i < 3; i++) step();
        start = 1'b0; in_valid = 1'b0;
        check("t2_hold_valid", out_valid, 1);
        check("t2_hold_acc",   $signed(acc_out), 50);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t2_taken_valid", out_valid, 0);
        check("t2_taken_busy",  busy, 0);

        // 3. IDLE ignores pairs; gapped beats still give 50
        in_valid = 1'b1; a = 8'd9; b = 8'd9;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        check("t3_idle_acc",  $signed(acc_out), 50);
        check("t3_idle_busy", busy, 0);
        do_start();
        begin
            int pa[4] = '{3, -2, 7, 1};
            int pb[4] = '{4, 5, 7, -1};
            for (int i = 0; i < 4; i++) begin
                a = 8'd100; b = 8'd100;
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
                beat(pa[i], pb[i]);
            end
        end
        check("t3_acc",       $signed(acc_out), 50);
        check("t3_out_valid", out_valid, 1);
        check("t3_overflow",  overflow, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 4. 16-bit accumulator overflow; single-term instance alongside
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        s_beat(127, 127);
        check("t4_n1_valid", o_out_valid, 1);
        check("t4_n1_acc",   $signed(o_acc), 16129);
        check("t4_ovf1",     w_overflow, 0);
        s_beat(127, 127);
        check("t4_acc2",     $signed(w_acc), 32258);
        check("t4_ovf2",     w_overflow, 0);
        s_beat(127, 127);
        check("t4_ovf3",     w_overflow, 1);
`ifdef MAC_SATURATE_EN
        check("t4_acc3",     $signed(w_acc), 32767);
`else
        check("t4_acc3",     $signed(w_acc), -17149);
`endif
        s_beat(127, 127);
`ifdef MAC_SATURATE_EN
        check("t4_acc4",     $signed(w_acc), 32767);
`else
        check("t4_acc4",     $signed(w_acc), -1020);
`endif
        check("t4_ovf4",     w_overflow, 1);
        check("t4_valid",    w_out_valid, 1);
        check("t4_n1_hold",  $signed(o_acc), 16129);
        s_ready = 1'b1;
        step();
        s_ready = 1'b0;

        // 5. reset mid-accumulation discards partial sum
        do_start();
        beat(3, 4);
        beat(-2, 5);
        check("t5_partial", $signed(acc_out), 2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("t5_rst_acc",   $signed(acc_out), 0);
        check("t5_rst_busy",  busy, 0);
        check("t5_rst_valid", out_valid, 0);
        do_start();
        beat(3, 4); beat(-2, 5); beat(7, 7); beat(1, -1);
        check("t5_acc",   $signed(acc_out), 50);
        check("t5_valid", out_valid, 1);

        // 6. back-to-back: 100 - 12 + 0 - 16 = 72
        out_ready = 1'b1; start = 1'b1;
        step();
        out_ready = 1'b0; start = 1'b0;
        check("t6_busy",  busy, 1);
        check("t6_acc",   $signed(acc_out), 0);
        check("t6_valid", out_valid, 0);
        beat(10, 10); beat(-3, 4); beat(0, 5); beat(2, -8);
        check("t6_sum",       $signed(acc_out), 72);
        check("t6_out_valid", out_valid, 1);
        check("t6_overflow",  overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
